// File: rtl/mau_pkg.sv
// Shared definitions for the load/store unit: FSM states, RV32I width codes
// and the request legality/alignment decode.
package mau_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_MERGE = 3'd3,
    ST_RESP  = 3'd4
  } mau_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // High when the request uses an unknown width code or is misaligned for its width.
  function automatic logic mau_bad_req(input logic       i_we,
                                       input logic [2:0] i_f3,
                                       input logic [1:0] i_addr_lo);
    logic bad;
    bad = 1'b1;
    if (i_we) begin
      case (i_f3)
        F3_SB:   bad = 1'b0;
        F3_SH:   bad = i_addr_lo[0];
        F3_SW:   bad = |i_addr_lo;
        default: bad = 1'b1;
      endcase
    end else begin
      case (i_f3)
        F3_LB, F3_LBU: bad = 1'b0;
        F3_LH, F3_LHU: bad = i_addr_lo[0];
        F3_LW:         bad = |i_addr_lo;
        default:       bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/mau_lane.sv
// Byte-lane steering: extracts and extends load data from a RAM word, and
// builds the merged word for sub-word stores.
module mau_lane
  import mau_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  // Load result: pick the addressed lane and sign- or zero-extend it.
  always_comb begin
    o_load = i_rdata;
    case (i_funct3)
      F3_LB:   o_load = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_load = {24'd0, w_byte};
      F3_LH:   o_load = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_load = {16'd0, w_half};
      default: o_load = i_rdata;
    endcase
  end

  // Store merge: keep the old word and overwrite only the addressed lane(s).
  always_comb begin
    o_merge = i_rdata;
    case (i_funct3)
      F3_SB: o_merge[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
      F3_SH: begin
        if (i_addr_lo[1]) o_merge[31:16] = i_wdata;
        else              o_merge[15:0]  = i_wdata;
      end
      default: o_merge = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// RV32I load/store unit in front of a word-wide synchronous RAM. One request
// at a time; sub-word stores are done as read-modify-write.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  mau_state_e        r_state;
  mau_state_e        w_next;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [1:0]        r_addr_lo;
  logic              r_err;
  logic [31:0]       r_mem_wdata;
  logic              r_mem_wen;
  logic              r_mem_ren;
  logic [ADDR_W-1:0] r_mem_waddr;
  logic [ADDR_W-1:0] r_mem_raddr;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [31:0]       r_resp_rdata;

  logic              w_accept;
  logic              w_bad;
  logic [ADDR_W-1:0] w_word;
  logic [31:0]       w_load;
  logic [31:0]       w_merge;
  logic              w_unused_addr;

  assign req_ready     = (r_state == ST_IDLE) && !rst;
  assign w_accept      = req_valid && req_ready;
  assign w_bad         = mau_bad_req(req_we, req_funct3, req_addr[1:0]);
  // Upper address bits wrap around: only the RAM-sized word index is kept.
  assign w_word        = req_addr[ADDR_W+1:2];
  assign w_unused_addr = ^req_addr[31:ADDR_W+2];

  mau_lane u_lane (
    .i_funct3  (r_funct3),
    .i_addr_lo (r_addr_lo),
    .i_rdata   (mem_rdata),
    .i_wdata   (r_mem_wdata[15:0]),
    .o_load    (w_load),
    .o_merge   (w_merge)
  );

  // Next-state decode: errors skip the RAM, SW writes directly, loads and
  // sub-word stores read first.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_bad)                     w_next = ST_RESP;
          else if (!req_we)              w_next = ST_READ;
          else if (req_funct3 == F3_SW)  w_next = ST_WRITE;
          else                           w_next = ST_READ;
        end
      end
      ST_READ:  w_next = r_we ? ST_MERGE : ST_RESP;
      ST_WRITE: w_next = ST_RESP;
      ST_MERGE: w_next = ST_RESP;
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // State, request latch, registered RAM strobes and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_we         <= 1'b0;
      r_funct3     <= 3'd0;
      r_addr_lo    <= 2'd0;
      r_err        <= 1'b0;
      r_mem_wdata  <= 32'd0;
      r_mem_wen    <= 1'b0;
      r_mem_ren    <= 1'b0;
      r_mem_waddr  <= '0;
      r_mem_raddr  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
    end else begin
      r_state   <= w_next;
      r_mem_ren <= (w_next == ST_READ);
      r_mem_wen <= (w_next == ST_WRITE) || (w_next == ST_MERGE);
      if (w_accept) begin
        r_we        <= req_we;
        r_funct3    <= req_funct3;
        r_addr_lo   <= req_addr[1:0];
        r_err       <= w_bad;
        r_mem_wdata <= req_wdata;
        r_mem_waddr <= w_word;
        r_mem_raddr <= w_word;
      end
      // RESP is the cycle in which load data from the RAM is present.
      r_resp_valid <= (r_state == ST_RESP);
      r_resp_err   <= (r_state == ST_RESP) && r_err;
      r_resp_rdata <= ((r_state == ST_RESP) && !r_err && !r_we) ? w_load : 32'd0;
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign mem_ren    = r_mem_ren;
  // A reset arriving during the merge cycle must not let the half-finished
  // read-modify-write land in the RAM, so the write strobe is masked by rst.
  assign mem_wen    = r_mem_wen && !rst;
  assign mem_waddr  = r_mem_waddr;
  assign mem_raddr  = r_mem_raddr;
  assign mem_wdata  = (r_state == ST_MERGE) ? w_merge : r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural RAM and a
// byte-level reference model of RV32I loads and stores.
module tb_mem_access_unit;

  localparam int ADDR_W = 14;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;
  logic              mem_wen;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_waddr;
  logic [ADDR_W-1:0] mem_raddr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_wen    (mem_wen),
    .mem_ren    (mem_ren),
    .mem_waddr  (mem_waddr),
    .mem_raddr  (mem_raddr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          acc;
    int          lat;
  } resp_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  resp_t             exp_q[$];
  wr_t               wr_q[$];
  logic [ADDR_W-1:0] rd_q[$];

  logic [31:0] ram   [DEPTH];
  logic [31:0] model [DEPTH];
  logic        init_go;
  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;
  logic [31:0] last_rdata;

  function automatic logic [31:0] seed_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM: read data appears the cycle after mem_ren.
  always @(posedge clk) begin
    if (init_go) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= seed_word(i);
    end else begin
      if (mem_wen) ram[mem_waddr] <= mem_wdata;
      if (mem_ren) mem_rdata <= ram[mem_raddr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every DUT output event is matched against the queued expectations.
  always @(negedge clk) begin
    check("strobe_exclusive", 32'(mem_wen && mem_ren), 32'd0);
    if (resp_valid) begin
      check("resp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        resp_t e;
        e = exp_q.pop_front();
        check("resp_err", 32'(resp_err), 32'(e.err));
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
      end
      last_rdata = resp_rdata;
    end
    if (mem_ren) begin
      check("read_expected", 32'(rd_q.size() != 0), 32'd1);
      if (rd_q.size() != 0) check("mem_raddr", 32'(mem_raddr), 32'(rd_q.pop_front()));
    end
    if (mem_wen) begin
      check("write_expected", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) begin
        wr_t w;
        w = wr_q.pop_front();
        check("mem_waddr", 32'(mem_waddr), 32'(w.addr));
        check("mem_wdata", mem_wdata, w.data);
      end
    end
  end

  // Reference model plus handshake: expectations are pushed in the accept cycle.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    int                bytes;
    int                off;
    logic              legal;
    logic              bad;
    logic [ADDR_W-1:0] idx;
    logic [63:0]       m64;
    logic [31:0]       mask;
    logic [31:0]       v;
    resp_t             e;
    bit                done;
    off   = int'(addr[1:0]);
    idx   = addr[ADDR_W+1:2];
    bytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
    bad   = !legal || ((off % bytes) != 0);
    m64   = (64'd1 << (8 * bytes)) - 64'd1;
    mask  = m64[31:0];
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    done = 0;
    for (int k = 0; k < 50 && !done; k++) begin
      if (req_ready) begin
        e.acc = cyc + 1;
        e.err = bad;
        e.rdata = 32'd0;
        if (bad) begin
          e.lat = 1;
        end else if (!we) begin
          v = (model[idx] >> (8 * off)) & mask;
          if (f3[2] == 1'b0 && bytes < 4 && v[8*bytes-1]) v = v | ~mask;
          e.rdata = v;
          e.lat = 2;
          rd_q.push_back(idx);
        end else if (bytes == 4) begin
          e.lat = 2;
          wr_q.push_back('{idx, wd});
          model[idx] = wd;
        end else begin
          e.lat = 3;
          rd_q.push_back(idx);
          v = (model[idx] & ~(mask << (8 * off))) | ((wd << (8 * off)) & (mask << (8 * off)));
          wr_q.push_back('{idx, v});
          model[idx] = v;
        end
        exp_q.push_back(e);
        done = 1;
        @(posedge clk);
      end else begin
        @(negedge clk);
      end
    end
    check("accept_in_time", 32'(done), 32'd1);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || !req_ready) && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check("drain_in_time", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] saved;
    logic [31:0] a;
    bit          seen;
    int          bad_words;
    rst = 1'b1;
    init_go = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_funct3 = 3'd0;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    for (int i = 0; i < DEPTH; i++) model[i] = seed_word(i);
    repeat (2) @(posedge clk);
    #1 init_go = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_wen", 32'(mem_wen), 32'd0);
    check("rst_mem_ren", 32'(mem_ren), 32'd0);
    check("rst_mem_waddr", 32'(mem_waddr), 32'd0);
    check("rst_mem_raddr", 32'(mem_raddr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    #1 check("ready_after_rst", 32'(req_ready), 32'd1);

    // Directed cases
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    issue(1'b1, 3'b000, 32'h11, 32'h00000055);
    wait_drain();
    check("ram_word4_after_sb", ram[4], 32'hDEAD55EF);
    issue(1'b0, 3'b000, 32'h13, 32'h0);
    wait_drain();
    check("lb_0x13", last_rdata, 32'hFFFFFFDE);
    issue(1'b0, 3'b100, 32'h13, 32'h0);
    wait_drain();
    check("lbu_0x13", last_rdata, 32'h000000DE);
    issue(1'b0, 3'b001, 32'h12, 32'h0);
    wait_drain();
    check("lh_0x12", last_rdata, 32'hFFFFDEAD);
    issue(1'b0, 3'b010, 32'h12, 32'h0);
    issue(1'b1, 3'b001, 32'h11, 32'h1234);
    issue(1'b0, 3'b011, 32'h10, 32'h0);
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    issue(1'b0, 3'b010, 32'h14, 32'h0);
    wait_drain();

    // Reset during the merge cycle of a byte store
    saved = model[8];
    issue(1'b1, 3'b000, 32'h21, 32'h000000AA);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (mem_wen) seen = 1;
    end
    check("merge_cycle_reached", 32'(seen), 32'd1);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_mem_wen", 32'(mem_wen), 32'd0);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    model[8] = saved;
    #1 check("abort_ready", 32'(req_ready), 32'd1);
    repeat (4) @(negedge clk);
    check("abort_ram_unchanged", ram[8], saved);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    wait_drain();
    check("read_queue_empty", 32'(rd_q.size()), 32'd0);
    check("write_queue_empty", 32'(wr_q.size()), 32'd0);
    bad_words = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== model[i]) bad_words++;
    check("ram_image", 32'(bad_words), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
